// File: rtl/xoodoo_perm_ctrl_sca.sv
// Sequencer for a DOM-masked Xoodoo round datapath, one round per cycle.
// Feeds the datapath from the input shares on round 0, then from its own
// registered output, and spends one fresh PRNG word per round.
module xoodoo_perm_ctrl_sca #(
   parameter int NROUNDS = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [383:0] state_in_0,
   input  logic [383:0] state_in_1,
   output logic         busy,
   output logic         done,
   output logic [3:0]   round_idx,
   output logic [383:0] state_out_0,
   output logic [383:0] state_out_1,
   input  logic         rnd_valid,
   input  logic [383:0] rnd_data,
   output logic         rnd_ready,
   output logic [383:0] dp_in_0,
   output logic [383:0] dp_in_1,
   input  logic [383:0] dp_out_0,
   input  logic [383:0] dp_out_1,
   output logic [383:0] dp_rdi,
   output logic         dp_rdi_en,
   output logic [31:0]  dp_rconst
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   // Shorter permutations use the tail of the constant table.
   localparam logic [3:0] RC_BASE = 4'(12 - NROUNDS);
   localparam logic [3:0] LAST    = 4'(NROUNDS - 1);

   logic [1:0] state;
   logic [3:0] cnt;
   logic       fire;

   function automatic logic [11:0] rc_lut(input logic [3:0] i);
      case (i)
         4'd0:    return 12'h058;
         4'd1:    return 12'h038;
         4'd2:    return 12'h3C0;
         4'd3:    return 12'h0D0;
         4'd4:    return 12'h120;
         4'd5:    return 12'h014;
         4'd6:    return 12'h060;
         4'd7:    return 12'h02C;
         4'd8:    return 12'h380;
         4'd9:    return 12'h0F0;
         4'd10:   return 12'h1A0;
         4'd11:   return 12'h012;
         default: return 12'h000;
      endcase
   endfunction

   // A round fires only when the PRNG offers a word while running.
   assign fire = (state == S_RUN) && rnd_valid;

   // FSM and round counter; cnt is left at NROUNDS after a run so it can be
   // read back as the round count until the next start.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  cnt   <= 4'd0;
               end
            end
            S_RUN: begin
               if (fire) begin
                  cnt <= cnt + 4'd1;
                  if (cnt == LAST) state <= S_FIN;
               end
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Control outputs come from registered state; only the fire strobe sees
   // rnd_valid, so rnd_ready never depends on it.
   always_comb begin
      busy      = (state == S_RUN);
      done      = (state == S_FIN);
      rnd_ready = (state == S_RUN);
      dp_rdi_en = fire;
      round_idx = cnt;
      dp_rconst = (state == S_RUN) ? {20'd0, rc_lut(RC_BASE + cnt)} : 32'd0;
   end

   // Round 0 loads the caller's shares; later rounds feed back the datapath.
   always_comb begin
      dp_in_0 = (cnt == 4'd0) ? state_in_0 : dp_out_0;
      dp_in_1 = (cnt == 4'd0) ? state_in_1 : dp_out_1;
   end

   assign dp_rdi      = rnd_data;
   assign state_out_0 = dp_out_0;
   assign state_out_1 = dp_out_1;

endmodule

// File: tb/tb_xoodoo_perm_ctrl_sca.sv
// Directed bench for xoodoo_perm_ctrl_sca. A stand-in masked round
// (rotate by one, add constant to share 0, refresh both shares with the PRNG
// word) makes the unmasked result order- and constant-sensitive.
module tb_xoodoo_perm_ctrl_sca;

   localparam logic [31:0] RC_TAB [12] = '{
      32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
      32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [383:0] state_in_0 = '0, state_in_1 = '0;
   logic         rnd_valid = 1'b0;
   logic [383:0] rnd_data = '0;

   logic         busy, done, rnd_ready, dp_rdi_en;
   logic [3:0]   round_idx;
   logic [383:0] state_out_0, state_out_1, dp_in_0, dp_in_1, dp_rdi;
   logic [31:0]  dp_rconst;
   logic [383:0] d0 = '0, d1 = '0;

   logic         busy6, done6, rnd_ready6, dp_rdi_en6;
   logic [3:0]   round_idx6;
   logic [383:0] so6_0, so6_1, dpi6_0, dpi6_1, rdi6;
   logic [31:0]  rconst6;
   logic [383:0] e0 = '0, e1 = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fires = 0, fires6 = 0, dones = 0;
   logic [31:0] rc_log  [256];
   logic [31:0] rc_log6 [256];

   always #5 clk = ~clk;

   xoodoo_perm_ctrl_sca #(.NROUNDS(12)) dut (
      .clk(clk), .rst(rst), .start(start),
      .state_in_0(state_in_0), .state_in_1(state_in_1),
      .busy(busy), .done(done), .round_idx(round_idx),
      .state_out_0(state_out_0), .state_out_1(state_out_1),
      .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
      .dp_in_0(dp_in_0), .dp_in_1(dp_in_1),
      .dp_out_0(d0), .dp_out_1(d1),
      .dp_rdi(dp_rdi), .dp_rdi_en(dp_rdi_en), .dp_rconst(dp_rconst));

   xoodoo_perm_ctrl_sca #(.NROUNDS(6)) dut6 (
      .clk(clk), .rst(rst), .start(start),
      .state_in_0(state_in_0), .state_in_1(state_in_1),
      .busy(busy6), .done(done6), .round_idx(round_idx6),
      .state_out_0(so6_0), .state_out_1(so6_1),
      .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready6),
      .dp_in_0(dpi6_0), .dp_in_1(dpi6_1),
      .dp_out_0(e0), .dp_out_1(e1),
      .dp_rdi(rdi6), .dp_rdi_en(dp_rdi_en6), .dp_rconst(rconst6));

   function automatic logic [383:0] rot1(input logic [383:0] x);
      return {x[382:0], x[383]};
   endfunction

   // Unmasked reference of the stand-in round over nr rounds.
   function automatic logic [383:0] xref(input logic [383:0] x, input int nr);
      logic [383:0] y;
      y = x;
      for (int i = 0; i < nr; i++) y = rot1(y) ^ {352'd0, RC_TAB[12-nr+i]};
      return y;
   endfunction

   function automatic logic [383:0] rand384();
      logic [383:0] r;
      for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   // Stand-in masked datapaths, cleared by reset, updated on fire.
   always @(posedge clk) begin
      if (!rst) begin
         d0 <= '0; d1 <= '0; e0 <= '0; e1 <= '0;
      end else begin
         if (dp_rdi_en) begin
            d0 <= rot1(dp_in_0) ^ dp_rdi ^ {352'd0, dp_rconst};
            d1 <= rot1(dp_in_1) ^ dp_rdi;
         end
         if (dp_rdi_en6) begin
            e0 <= rot1(dpi6_0) ^ rdi6 ^ {352'd0, rconst6};
            e1 <= rot1(dpi6_1) ^ rdi6;
         end
      end
   end

   // Fire/constant/done monitors sampled on the active edge.
   always @(posedge clk) begin
      if (rst && dp_rdi_en) begin
         rc_log[fires[7:0]] <= dp_rconst;
         fires <= fires + 1;
      end
      if (rst && dp_rdi_en6) begin
         rc_log6[fires6[7:0]] <= rconst6;
         fires6 <= fires6 + 1;
      end
      if (rst && done) dones <= dones + 1;
   end

   task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      rnd_data = rand384();
   endtask

   // Start then wait for done; lat counts cycles from the start cycle.
   task automatic run_perm(output int lat);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      chk("done_seen", done, 1'b1);
   endtask

   task automatic load(input logic [383:0] x);
      state_in_0 = rand384();
      state_in_1 = state_in_0 ^ x;
   endtask

   initial begin
      int lat, b, b6, dn, sc;
      logic [383:0] x, y, so, r1;

      // Reset state
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ready", rnd_ready, 1'b0);
      chk("rst_idx", round_idx, 4'd0);
      chk("rst_rconst", dp_rconst, 32'd0);
      chk("rst_out", state_out_0 | state_out_1, '0);
      rst = 1'b1;
      tick();

      // 1+2: no stalls, all-zero unmasked state; constant sequences
      load('0);
      rnd_valid = 1'b1;
      b = fires; b6 = fires6;
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      chk("t1_busy", busy, 1'b1);
      chk("t1_ready", rnd_ready, 1'b1);
      chk("t1_en", dp_rdi_en, 1'b1);
      chk("t1_dpin_sel0", dp_in_0, state_in_0);
      chk("t1_rdi", dp_rdi, rnd_data);
      tick();
      chk("t1_dpin_fb", dp_in_1, d1);
      lat = 2;
      while (done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      chk("t1_latency", lat, 13);
      chk("t1_result", state_out_0 ^ state_out_1, xref('0, 12));
      chk("t1_words", fires - b, 12);
      chk("t1_idx", round_idx, 4'd12);
      chk("t1_busy_fin", busy, 1'b0);
      for (int i = 0; i < 12; i++) chk("t2_rc12", rc_log[b+i], RC_TAB[i]);
      chk("t2_words6", fires6 - b6, 6);
      for (int i = 0; i < 6; i++) chk("t2_rc6", rc_log6[b6+i], RC_TAB[6+i]);
      chk("t2_result6", so6_0 ^ so6_1, xref('0, 6));
      chk("t2_idx6", round_idx6, 4'd6);
      tick();
      chk("t1_done_pulse", done, 1'b0);
      chk("t1_idx_hold", round_idx, 4'd12);
      chk("t1_rconst_idle", dp_rconst, 32'd0);
      so = state_out_0;
      tick();
      chk("t1_out_hold", state_out_0, so);

      // 3: PRNG stalls of 3 cycles before round 5 and 1 before round 12
      load('0);
      b = fires;
      sc = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rnd_valid = 1'b0;
      #1;
      chk("t3_idx4", round_idx, 4'd4);
      so = state_out_0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_noen", dp_rdi_en, 1'b0);
         tick();
         chk("t3_frozen", state_out_0, so);
      end
      chk("t3_idx_stall", round_idx, 4'd4);
      rnd_valid = 1'b1;
      repeat (7) tick();
      rnd_valid = 1'b0;
      #1;
      chk("t3_idx11", round_idx, 4'd11);
      chk("t3_noen2", dp_rdi_en, 1'b0);
      tick();
      rnd_valid = 1'b1;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      chk("t3_latency", cyc - sc, 17);
      chk("t3_words", fires - b, 12);
      chk("t3_result", state_out_0 ^ state_out_1, xref('0, 12));
      tick();

      // 4: start pulses while running and at the done cycle are ignored
      x = rand384();
      load(x);
      dn = dones;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_idx_norestart", round_idx, 4'd4);
      lat = 5;
      while (done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      chk("t4_latency", lat, 13);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_busy_after", busy, 1'b0);
      chk("t4_idx_after", round_idx, 4'd12);
      repeat (3) tick();
      chk("t4_not_queued", busy, 1'b0);
      chk("t4_one_done", dones - dn, 1);
      chk("t4_result", state_out_0 ^ state_out_1, xref(x, 12));

      // 5: reset mid-permutation after round 7
      dn = dones;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      chk("t5_idx7", round_idx, 4'd7);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("t5_busy", busy, 1'b0);
      chk("t5_idx", round_idx, 4'd0);
      chk("t5_ready", rnd_ready, 1'b0);
      chk("t5_en", dp_rdi_en, 1'b0);
      chk("t5_rconst", dp_rconst, 32'd0);
      chk("t5_out", state_out_0 | state_out_1, '0);
      repeat (15) tick();
      chk("t5_no_done", dones - dn, 0);
      x = rand384();
      load(x);
      run_perm(lat);
      chk("t5_latency", lat, 13);
      chk("t5_result", state_out_0 ^ state_out_1, xref(x, 12));

      // 6: back-to-back start right after done uses fresh state_in
      tick();
      y = rand384();
      load(y);
      run_perm(lat);
      chk("t6_b2b_latency", lat, 13);
      r1 = state_out_0 ^ state_out_1;
      chk("t6_b2b_result", r1, xref(y, 12));
      tick();
      load(y);
      run_perm(lat);
      chk("t6_mask_indep", state_out_0 ^ state_out_1, r1);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xoodoo_perm_ctrl_sca.md
# xoodoo_perm_ctrl_SCA

Sequencer for the first-order DOM-masked Xoodoo round datapath, one round per cycle. It runs a full Xoodoo permutation of NROUNDS rounds over a two-share state. It drives the round's feedback multiplexer, round constant and enable, and pulls 384 bits of fresh randomness per round from the PRNG over a valid/ready handshake, stalling when none is available. It sits between the Xoodyak cyclist control logic (start/done) and one instance of the masked round datapath.

## Interface
Parameters:
- NROUNDS, 12: rounds per permutation, legal range 1..12. The last NROUNDS entries of the Xoodoo constant table are used.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset). The parent drives the round datapath's active-high reset with ~rst.
- start  in  1  permutation request; accepted only in IDLE.
- state_in_0 / state_in_1  in  384 each  input state shares, 12 lanes × 32 bits, lane i at [32i+:32].
- busy  out  1  high from the cycle after an accepted start through the cycle before done.
- done  out  1  one-cycle pulse; state_out is valid this cycle.
- round_idx  out  4  number of rounds already applied in the current permutation.
- state_out_0 / state_out_1  out  384 each  permutation result shares; combinational pass-through of dp_out_0/1.
- rnd_valid  in  1  PRNG word available.
- rnd_data  in  384  PRNG word.
- rnd_ready  out  1  controller consumes rnd_data this cycle if rnd_valid.
- dp_in_0 / dp_in_1  out  384 each  round datapath input shares.
- dp_out_0 / dp_out_1  in  384 each  round datapath output shares (registered inside the datapath).
- dp_rdi  out  384  randomness to the datapath; equals rnd_data.
- dp_rdi_en  out  1  round fire; the datapath register updates on this.
- dp_rconst  out  32  round constant, zero-extended.

## Operation
- FSM states: IDLE, RUN, FIN. Counter cnt is 4 bits.
- IDLE:
  - rnd_ready = 0.
  - start = 1 → RUN, cnt ← 0.
- RUN:
  - rnd_ready = 1, dp_rdi_en = rnd_valid.
  - A fire is a cycle with rnd_valid & rnd_ready. Each fire increments cnt.
  - The fire with cnt == NROUNDS-1 → FIN.
  - No fire: hold state and cnt. dp_rdi_en = 0, so the datapath register holds.
- FIN:
  - done = 1 for this cycle only.
  - Next state is IDLE unconditionally.
  - A start seen in FIN is ignored.
- Input mux:
  - dp_in_x = state_in_x while cnt == 0.
  - dp_in_x = dp_out_x otherwise.
  - The caller holds state_in stable from start until the first fire.
- dp_rconst = RC[12 - NROUNDS + cnt], with RC[0..11]:
  - 0x058, 0x038, 0x3C0, 0x0D0, 0x120, 0x014,
  - 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012.
- dp_rconst = 0 outside RUN.
- dp_rdi = rnd_data at all times. It is only meaningful when dp_rdi_en = 1.
- Randomness usage: exactly one PRNG word per round, never reused. No word is consumed outside RUN.
- round_idx = cnt. It holds NROUNDS through FIN and IDLE until the next start is accepted.
- busy = 1 exactly in RUN.
- start while RUN or FIN is ignored and is not queued.
- After done, state_out holds its value until the next fire, because the datapath register only moves on dp_rdi_en.
- Reset (rst = 0), in any state including mid-permutation:
  - next cycle: state IDLE, cnt = 0, busy = 0, done = 0, rnd_ready = 0, dp_rdi_en = 0, dp_rconst = 0;
  - datapath shares are cleared to 0 by its own reset;
  - a partially computed permutation is discarded and never flagged done.

## Timing
- Start accepted at edge T → RUN from cycle T+1.
- With rnd_valid constantly high:
  - fires in cycles T+1 .. T+NROUNDS;
  - done in cycle T+NROUNDS+1;
  - earliest next start accepted in cycle T+NROUNDS+2.
- Total latency: NROUNDS + 1 + (number of stall cycles), measured from the start cycle to the done cycle.
- All control outputs are decoded from registered state only, except:
  - dp_rdi_en = f(state, rnd_valid);
  - dp_in mux select is decoded from registered cnt.
- There is no combinational path from rnd_valid to rnd_ready.

## Test plan
1. **Single permutation, no stalls.** Shares random with share0^share1 = 0; rnd_valid = 1; NROUNDS = 12.
   - done exactly 13 cycles after start.
   - state_out_0 ^ state_out_1 equals the unmasked Xoodoo-12 reference of the all-zero state.
   - Exactly 12 PRNG words consumed.
2. **Constant sequence.** Monitor dp_rconst on each fire.
   - NROUNDS = 12: 0x058 … 0x012 in table order.
   - NROUNDS = 6: 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012.
3. **PRNG stalls.** rnd_valid toggles low for 3 cycles before round 5 and 1 cycle before round 12.
   - No fire during the low cycles; datapath output frozen.
   - done at cycle start+17.
   - Unmasked result identical to scenario 1 with the same input.
4. **Start while busy.** Pulse start at cycles start+4 and at the done cycle.
   - Both are ignored.
   - Exactly one done pulse; round_idx never restarts.
5. **Mid-run reset.** Assert rst = 0 for 1 cycle after round 7.
   - Next cycle: busy = 0, round_idx = 0, rnd_ready = 0, state_out = 0.
   - No done pulse.
   - A new start then completes normally with the correct result.
6. **Back-to-back and masking independence.**
   - Two permutations with start asserted in the cycle after done: the second uses state_in, not the prior output.
   - Different random share splits of the same unmasked input give identical unmasked outputs.
